mos_strength_rx: RTL and testbench

- Receiving end of the pass-gate strength link. Upstream, each cycle, an NMOS/PMOS pair drives payload bit `a` onto `zn` when `c`=1 or onto `zp` when `c`=0. The undriven output floats (Z).
- This block samples the two strength-coded lines and recovers `a` and `c` for each symbol.
- It deserialises symbols into WIDTH-bit words and hands them to a consumer over valid/ready, with contention and framing error tracking.
- It sits between the strength-link sampler (synchronised codes) and digital logic.

---
 rtl/mos_strength_rx_if.sv | 27 ++
 rtl/mos_strength_rx.sv | 155 +++++++++++++++
 tb/tb_mos_strength_rx.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mos_strength_rx_if.sv
// rtl/mos_strength_rx_if.sv - strength-link receiver bus: line codes in, word handshake and error status out
interface mos_strength_rx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [1:0]       zn_code;
    logic [1:0]       zp_code;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_ctl;
    logic             out_valid;
    logic             out_ready;
    logic             clr_err;
    logic [CNT_W-1:0] err_cnt;
    logic             short_err;
    logic             ovf_err;
    logic             busy;

    modport master (
        output zn_code, zp_code, out_ready, clr_err,
        input  out_data, out_ctl, out_valid, err_cnt, short_err, ovf_err, busy
    );

    modport slave (
        input  zn_code, zp_code, out_ready, clr_err,
        output out_data, out_ctl, out_valid, err_cnt, short_err, ovf_err, busy
    );
endinterface

// File: rtl/mos_strength_rx.sv
// rtl/mos_strength_rx.sv - pass-gate strength-link receiver: symbol decode, deserialiser, output register, error tracking
module mos_strength_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    mos_strength_rx_if.slave   bus
);
    localparam int             CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
    localparam logic [1:0]     HIZ     = 2'b10;
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ERR_WAIT} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_sh_data, r_sh_ctl, w_sh_data_nxt, w_sh_ctl_nxt, w_onehot;
    logic [WIDTH-1:0] r_out_data, r_out_ctl;
    logic             r_valid;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_short, r_ovf;
    logic             w_n_sym, w_p_sym, w_idle_sym, w_err_sym, w_np_sym;
    logic             w_bit, w_ctl;
    logic             w_complete, w_err_inc, w_short_set;

    // Classify the current pair of line codes; a driven line is St0/St1 (MSB clear)
    always_comb begin
        w_n_sym    = !bus.zn_code[1] && (bus.zp_code == HIZ);
        w_p_sym    = !bus.zp_code[1] && (bus.zn_code == HIZ);
        w_idle_sym = (bus.zn_code == HIZ) && (bus.zp_code == HIZ);
        w_np_sym   = w_n_sym || w_p_sym;
        w_err_sym  = !(w_np_sym || w_idle_sym);
        w_ctl      = w_n_sym;
        w_bit      = w_n_sym ? bus.zn_code[0] : bus.zp_code[0];
    end

    // Next-state, symbol assembly and error events
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_sh_data_nxt = r_sh_data;
        w_sh_ctl_nxt  = r_sh_ctl;
        w_complete    = 1'b0;
        w_err_inc     = 1'b0;
        w_short_set   = 1'b0;
        w_onehot      = WIDTH'(1) << r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_np_sym) begin
                    w_sh_data_nxt = WIDTH'(w_bit);
                    w_sh_ctl_nxt  = WIDTH'(w_ctl);
                    w_cnt_nxt     = CW'(1);
                    w_state_nxt   = S_SHIFT;
                end else if (w_err_sym) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_ERR_WAIT;
                end
            end
            S_SHIFT: begin
                if (w_np_sym) begin
                    w_sh_data_nxt = r_sh_data | (w_bit ? w_onehot : '0);
                    w_sh_ctl_nxt  = r_sh_ctl  | (w_ctl ? w_onehot : '0);
                    if (r_cnt == LAST) begin
                        w_complete  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else if (w_idle_sym) begin
                    w_short_set = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_err_inc   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ERR_WAIT;
                end
            end
            S_ERR_WAIT: begin
                w_err_inc = w_err_sym;
                if (w_idle_sym) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, symbol counter and shift registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sh_data <= '0;
            r_sh_ctl  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sh_data <= w_sh_data_nxt;
            r_sh_ctl  <= w_sh_ctl_nxt;
        end
    end

    // Single-entry output register; a completion while full and not draining is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_ctl  <= '0;
            r_valid    <= 1'b0;
        end else if (w_complete && (!r_valid || bus.out_ready)) begin
            r_out_data <= w_sh_data_nxt;
            r_out_ctl  <= w_sh_ctl_nxt;
            r_valid    <= 1'b1;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating error counter and sticky flags; clear beats a same-cycle event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
            r_short   <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (bus.clr_err) begin
            r_err_cnt <= '0;
            r_short   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_err_inc && (r_err_cnt != ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (w_short_set) begin
                r_short <= 1'b1;
            end
            if (w_complete && r_valid && !bus.out_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_ctl   = r_out_ctl;
    assign bus.out_valid = r_valid;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.short_err = r_short;
    assign bus.ovf_err   = r_ovf;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_mos_strength_rx.sv
// tb/tb_mos_strength_rx.sv - self-checking bench for mos_strength_rx
module tb_mos_strength_rx;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic pre_valid, lat_valid;
    logic [2*WIDTH-1:0] sb[$];

    always #5 clk = ~clk;

    mos_strength_rx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mos_strength_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic drive(input logic [1:0] zn, input logic [1:0] zp);
        @(negedge clk);
        pre_valid   = bus.out_valid;
        bus.zn_code = zn;
        bus.zp_code = zp;
    endtask

    task automatic sym(input logic is_n, input logic b);
        if (is_n) drive({1'b0, b}, 2'b10);
        else      drive(2'b10, {1'b0, b});
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] c,
                              input bit expect_it, input bit trail_idle);
        for (int i = 0; i < WIDTH; i++) sym(c[i], d[i]);
        if (expect_it) sb.push_back({c, d});
        if (trail_idle) begin
            @(negedge clk);
            lat_valid   = bus.out_valid;
            bus.zn_code = 2'b10;
            bus.zp_code = 2'b10;
        end
    endtask

    task automatic recv_word(input string name);
        logic [2*WIDTH-1:0] exp_w;
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL %s timeout out_valid=%0b want 1", name, bus.out_valid);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected word got %h want none", name, {bus.out_ctl, bus.out_data});
        end else begin
            exp_w = sb.pop_front();
            if ({bus.out_ctl, bus.out_data} !== exp_w) begin
                errors++;
                $display("FAIL %s word got %h want %h", name, {bus.out_ctl, bus.out_data}, exp_w);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.zn_code = 2'b10; bus.zp_code = 2'b10;
        bus.out_ready = 1'b0; bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_ctl, bus.out_data} !== '0) begin
            errors++; $display("FAIL reset_out got %h want 0", {bus.out_valid, bus.out_ctl, bus.out_data});
        end
        checks++;
        if ({bus.err_cnt, bus.short_err, bus.ovf_err, bus.busy} !== '0) begin
            errors++; $display("FAIL reset_status got %h want 0", {bus.err_cnt, bus.short_err, bus.ovf_err, bus.busy});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        send_frame(8'h8D, 8'h4D, 1'b1, 1'b1);
        checks++;
        if (pre_valid !== 1'b0 || lat_valid !== 1'b1) begin
            errors++; $display("FAIL basic_latency got pre=%0b post=%0b want 0 1", pre_valid, lat_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h8D || bus.out_ctl !== 8'h4D) begin
            errors++; $display("FAIL basic_hold got v=%0b d=%h c=%h want 1 8d 4d", bus.out_valid, bus.out_data, bus.out_ctl);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_busy got %0b want 0", bus.busy);
        end
        recv_word("basic_word");
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_drain got %0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_short();
        logic [WIDTH-1:0] d, c;
        sym(1'b1, 1'b1); sym(1'b0, 1'b0); sym(1'b1, 1'b0);
        drive(2'b10, 2'b10);
        @(negedge clk);
        checks++;
        if (bus.short_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL short_flag got s=%0b v=%0b b=%0b want 1 0 0", bus.short_err, bus.out_valid, bus.busy);
        end
        clr_pulse();
        checks++;
        if (bus.short_err !== 1'b0) begin
            errors++; $display("FAIL short_clear got %0b want 0", bus.short_err);
        end
        d = WIDTH'($urandom); c = WIDTH'($urandom);
        send_frame(d, c, 1'b1, 1'b1);
        recv_word("short_next_word");
    endtask

    task automatic test_contention();
        sym(1'b1, 1'b1); sym(1'b0, 1'b1);
        drive(2'b01, 2'b00);
        @(negedge clk);
        checks++;
        if (bus.err_cnt !== 8'd1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL cont_err got cnt=%0d busy=%0b want 1 1", bus.err_cnt, bus.busy);
        end
        bus.zn_code = 2'b00; bus.zp_code = 2'b10;
        sym(1'b0, 1'b1);
        drive(2'b10, 2'b10);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.err_cnt !== 8'd1) begin
            errors++; $display("FAIL cont_recover got b=%0b v=%0b cnt=%0d want 0 0 1", bus.busy, bus.out_valid, bus.err_cnt);
        end
        for (int i = 0; i < 300; i++) drive(2'b11, 2'b10);
        drive(2'b10, 2'b10);
        @(negedge clk);
        checks++;
        if (bus.err_cnt !== 8'd255) begin
            errors++; $display("FAIL cont_saturate got %0d want 255", bus.err_cnt);
        end
        drive(2'b11, 2'b11);
        drive(2'b10, 2'b10);
        @(negedge clk);
        checks++;
        if (bus.err_cnt !== 8'd255) begin
            errors++; $display("FAIL cont_sat_hold got %0d want 255", bus.err_cnt);
        end
        clr_pulse();
        checks++;
        if (bus.err_cnt !== 8'd0) begin
            errors++; $display("FAIL cont_clear got %0d want 0", bus.err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] d1, c1, d2, c2, d4, c4;
        logic [2*WIDTH-1:0] exp_w;
        d1 = WIDTH'($urandom); c1 = WIDTH'($urandom);
        d2 = ~d1; c2 = WIDTH'($urandom);
        send_frame(d1, c1, 1'b1, 1'b0);
        send_frame(d2, c2, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.ovf_err !== 1'b1) begin
            errors++; $display("FAIL b2b_ovf got %0b want 1", bus.ovf_err);
        end
        recv_word("b2b_first_held");
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_dropped got %0b want 0", bus.out_valid);
        end
        clr_pulse();
        d1 = WIDTH'($urandom); c1 = WIDTH'($urandom);
        d4 = WIDTH'($urandom); c4 = WIDTH'($urandom);
        send_frame(d1, c1, 1'b1, 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) sym(c4[i], d4[i]);
        @(negedge clk);
        exp_w = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_ctl, bus.out_data} !== exp_w) begin
            errors++; $display("FAIL b2b_third got v=%0b w=%h want 1 %h", bus.out_valid, {bus.out_ctl, bus.out_data}, exp_w);
        end
        bus.out_ready = 1'b1;
        if (c4[WIDTH-1]) begin bus.zn_code = {1'b0, d4[WIDTH-1]}; bus.zp_code = 2'b10; end
        else             begin bus.zn_code = 2'b10; bus.zp_code = {1'b0, d4[WIDTH-1]}; end
        sb.push_back({c4, d4});
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.zn_code = 2'b10; bus.zp_code = 2'b10;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.ovf_err !== 1'b0) begin
            errors++; $display("FAIL b2b_accept_load got v=%0b ovf=%0b want 1 0", bus.out_valid, bus.ovf_err);
        end
        recv_word("b2b_fourth");
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] d, c;
        d = WIDTH'($urandom); c = WIDTH'($urandom);
        send_frame(~d, c, 1'b0, 1'b1);
        drive(2'b11, 2'b11);
        drive(2'b10, 2'b10);
        for (int i = 0; i < 5; i++) sym(c[i], d[i]);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_ctl, bus.out_data, bus.err_cnt, bus.busy} !== '0) begin
            errors++; $display("FAIL rstmid_async got v=%0b d=%h cnt=%0d b=%0b want 0", bus.out_valid, bus.out_data, bus.err_cnt, bus.busy);
        end
        #1 rst = 1'b0;
        for (int i = 5; i < WIDTH; i++) sym(c[i], d[i]);
        drive(2'b10, 2'b10);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.short_err !== 1'b1) begin
            errors++; $display("FAIL rstmid_no_word got v=%0b s=%0b want 0 1", bus.out_valid, bus.short_err);
        end
        clr_pulse();
        send_frame(d, c, 1'b1, 1'b1);
        recv_word("rstmid_next_word");
    endtask

    task automatic test_clr_same();
        drive(2'b11, 2'b10);
        drive(2'b10, 2'b10);
        @(negedge clk);
        checks++;
        if (bus.err_cnt !== 8'd1) begin
            errors++; $display("FAIL clr_pre got %0d want 1", bus.err_cnt);
        end
        bus.zn_code = 2'b11; bus.zp_code = 2'b11; bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0; bus.zn_code = 2'b10; bus.zp_code = 2'b10;
        checks++;
        if (bus.err_cnt !== 8'd0) begin
            errors++; $display("FAIL clr_same got %0d want 0", bus.err_cnt);
        end
        drive(2'b11, 2'b10);
        drive(2'b10, 2'b10);
        @(negedge clk);
        checks++;
        if (bus.err_cnt !== 8'd1) begin
            errors++; $display("FAIL clr_after got %0d want 1", bus.err_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_clr_same();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
